// File: rtl/pkt_wrr_pkg.sv
// pkt_wrr_pkg: shared constants and types for the packet WRR scheduler.
//   DATA_W     width of one UM packet word (2-bit header + 132-bit payload)
//   HDR_*      header codes carried in word bits [133:132]
//   wrr_state_e  scheduler FSM encoding
package pkt_wrr_pkg;

  localparam int DATA_W = 134;

  localparam logic [1:0] HDR_START = 2'b01;
  localparam logic [1:0] HDR_MID   = 2'b11;
  localparam logic [1:0] HDR_END   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wrr_state_e;

endpackage

// File: rtl/pkt_wrr_pick.sv
// pkt_wrr_pick: circular first-eligible search, purely combinational.
// Ports:
//   eligible      per-port eligibility vector
//   ptr           current round-robin pointer; search starts at ptr+1
//   pick_idx      first eligible port in ptr+1, ptr+2, ... ptr (modulo NUM_PORTS)
//   any_eligible  at least one port is eligible (pick_idx is meaningless otherwise)
module pkt_wrr_pick
  import pkt_wrr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [PTR_W-1:0]     ptr,
  output logic [PTR_W-1:0]     pick_idx,
  output logic                 any_eligible
);

  logic [PTR_W-1:0] idx;

  // Walk from the farthest offset down to the nearest so the closest
  // eligible port after ptr is the last one written. ptr itself is offset
  // NUM_PORTS, so it only wins when it is the sole eligible port.
  always_comb begin
    pick_idx = ptr;
    idx      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PTR_W'((32'(ptr) + 32'(k)) % 32'(NUM_PORTS));
      if (eligible[idx]) pick_idx = idx;
    end
  end

  assign any_eligible = |eligible;

endmodule

// File: rtl/pkt_wrr_sched.sv
// pkt_wrr_sched: packet-granular weighted round-robin onto the UM pktin bus.
// Optional feature macro: PKT_WRR_STATS_EN (per-port forwarded-packet counters;
// when undefined stat_pkt_cnt is tied to zero and no counter flops exist).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_weight           per-port weight (0 disables the port)
//   q_pkt_valid          per-port "complete packet queued"
//   q_vfifo_rd           one-cycle valid-FIFO pop at packet start
//   q_dfifo_rd           data-FIFO pop, every cycle of the packet
//   q_dfifo_rdata        show-ahead data-FIFO head words
//   pktin_ready          UM can accept one full packet (sampled in IDLE only)
//   pktin_data_wr/_data  registered packet stream toward UM
//   pktin_data_valid_wr  end-of-packet strobe; pktin_data_valid mirrors it
//   stat_pkt_cnt         per-port forwarded-packet counters
//
// state | meaning
// IDLE  | waiting for pktin_ready and an eligible port; WRR grant decided here
// SEND  | popping the granted queue word by word until the end header
module pkt_wrr_sched
  import pkt_wrr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight,
  input  logic [NUM_PORTS-1:0]        q_pkt_valid,
  output logic [NUM_PORTS-1:0]        q_vfifo_rd,
  output logic [NUM_PORTS-1:0]        q_dfifo_rd,
  input  logic [NUM_PORTS*DATA_W-1:0] q_dfifo_rdata,
  input  logic                        pktin_ready,
  output logic                        pktin_data_wr,
  output logic [DATA_W-1:0]           pktin_data,
  output logic                        pktin_data_valid_wr,
  output logic                        pktin_data_valid,
  output logic [NUM_PORTS*32-1:0]     stat_pkt_cnt
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  wrr_state_e          state_q, state_d;
  logic [PTR_W-1:0]    sel_q, sel_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                first_q, first_d;

  logic [DATA_W-1:0]   rdata_arr  [NUM_PORTS];
  logic [WEIGHT_W-1:0] weight_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic [PTR_W-1:0]    pick_idx;
  logic                any_eligible;
  logic                end_word;
  logic                send_end;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign rdata_arr[i]  = q_dfifo_rdata[i*DATA_W +: DATA_W];
    assign weight_arr[i] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
    assign eligible[i]   = q_pkt_valid[i] & (weight_arr[i] != '0);
  end

  pkt_wrr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .eligible     (eligible),
    .ptr          (ptr_q),
    .pick_idx     (pick_idx),
    .any_eligible (any_eligible)
  );

  assign end_word = (rdata_arr[sel_q][DATA_W-1 -: 2] == HDR_END);
  assign send_end = (state_q == SEND) && end_word;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    first_d    = 1'b0;
    q_dfifo_rd = '0;
    q_vfifo_rd = '0;
    case (state_q)
      IDLE: begin
        if (pktin_ready && any_eligible) begin
          if (eligible[ptr_q] && (credit_q != '0)) begin
            sel_d    = ptr_q;
            credit_d = credit_q - 1'b1;
          end else begin
            // Moving the pointer reloads credit, so any leftover credit of
            // the previous port is dropped here.
            sel_d    = pick_idx;
            ptr_d    = pick_idx;
            credit_d = weight_arr[pick_idx] - 1'b1;
          end
          first_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        q_dfifo_rd[sel_q] = 1'b1;
        q_vfifo_rd[sel_q] = first_q;
        if (end_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= PTR_W'(NUM_PORTS - 1);
      credit_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      first_q  <= first_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktin_data          <= '0;
      pktin_data_wr       <= 1'b0;
      pktin_data_valid_wr <= 1'b0;
    end else begin
      pktin_data_wr       <= (state_q == SEND);
      pktin_data_valid_wr <= send_end;
      if (state_q == SEND) pktin_data <= rdata_arr[sel_q];
    end
  end

  assign pktin_data_valid = pktin_data_valid_wr;

`ifdef PKT_WRR_STATS_EN
  logic [31:0] cnt_q [NUM_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (send_end) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat
    assign stat_pkt_cnt[i*32 +: 32] = cnt_q[i];
  end
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_wrr_sched.sv
// tb_pkt_wrr_sched: self-checking bench for pkt_wrr_sched.
// Upstream queues are modelled in the bench; every packet pushed is also held
// per port, and the expected pktin word stream is queued in the grant order
// the WRR rules dictate for each scenario, then compared as words emerge.
module tb_pkt_wrr_sched;
  import pkt_wrr_pkg::*;

  localparam int NP = 4;
  localparam int WW = 4;
  typedef logic [DATA_W-1:0] w_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NP*WW-1:0]     cfg_weight;
  logic [NP-1:0]        q_pkt_valid;
  logic [NP-1:0]        q_vfifo_rd;
  logic [NP-1:0]        q_dfifo_rd;
  logic [NP*DATA_W-1:0] q_dfifo_rdata;
  logic                 pktin_ready;
  logic                 pktin_data_wr;
  logic [DATA_W-1:0]    pktin_data;
  logic                 pktin_data_valid_wr;
  logic                 pktin_data_valid;
  logic [NP*32-1:0]     stat_pkt_cnt;

  pkt_wrr_sched #(.NUM_PORTS(NP), .WEIGHT_W(WW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_weight          (cfg_weight),
    .q_pkt_valid         (q_pkt_valid),
    .q_vfifo_rd          (q_vfifo_rd),
    .q_dfifo_rd          (q_dfifo_rd),
    .q_dfifo_rdata       (q_dfifo_rdata),
    .pktin_ready         (pktin_ready),
    .pktin_data_wr       (pktin_data_wr),
    .pktin_data          (pktin_data),
    .pktin_data_valid_wr (pktin_data_valid_wr),
    .pktin_data_valid    (pktin_data_valid),
    .stat_pkt_cnt        (stat_pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  w_t dq   [NP][$];
  w_t pend [NP][$];
  int plen [NP][$];
  int pcnt [NP];
  w_t exp_q[$];
  w_t mon_e;

  int vf_cnt [NP];
  int df_cnt [NP];
  int wr_cnt, vwr_cnt, first_vf_cyc, first_wr_cyc, last_end, cyc, seq;
  bit gap_chk = 1'b0;
  logic [NP-1:0] dpop = '0;
  logic [NP-1:0] vpop = '0;

  task automatic chk(input string tag, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      q_dfifo_rdata[i*DATA_W +: DATA_W] = (dq[i].size() > 0) ? dq[i][0] : '0;
      q_pkt_valid[i] = (pcnt[i] > 0);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NP; i++) begin
      vf_cnt[i] = 0;
      df_cnt[i] = 0;
    end
    wr_cnt = 0; vwr_cnt = 0;
    first_vf_cyc = -1; first_wr_cyc = -1; last_end = -1;
  endtask

  task automatic set_w(input logic [3:0] w0, input logic [3:0] w1,
                       input logic [3:0] w2, input logic [3:0] w3);
    cfg_weight = {w3, w2, w1, w0};
  endtask

  task automatic push_pkt(input int p, input int len);
    w_t w;
    for (int k = 0; k < len; k++) begin
      w = '0;
      w[DATA_W-1 -: 2] = (k == 0) ? HDR_START : ((k == len - 1) ? HDR_END : HDR_MID);
      w[127:96] = $urandom();
      w[31:24]  = 8'(p);
      w[23:8]   = 16'(seq);
      w[7:0]    = 8'(k);
      dq[p].push_back(w);
      pend[p].push_back(w);
    end
    plen[p].push_back(len);
    pcnt[p]++;
    seq++;
    refresh();
  endtask

  task automatic expect_port(input int p);
    int n;
    n = plen[p].pop_front();
    for (int k = 0; k < n; k++) exp_q.push_back(pend[p].pop_front());
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", w_t'(exp_q.size()), w_t'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NP; i++) begin
      dq[i].delete(); pend[i].delete(); plen[i].delete(); pcnt[i] = 0;
    end
    exp_q.delete();
    refresh();
    clear_counts();
    #1;
    chk("rst_async_wr",  w_t'({pktin_data_wr, pktin_data_valid_wr, pktin_data_valid}), w_t'(0));
    chk("rst_async_data", pktin_data, w_t'(0));
    chk("rst_async_rd",  w_t'({q_vfifo_rd, q_dfifo_rd}), w_t'(0));
    @(negedge clk);
    chk("rst_edge_out",  w_t'({pktin_data_wr, pktin_data_valid_wr, q_vfifo_rd, q_dfifo_rd}), w_t'(0));
    chk("rst_stat",      w_t'(stat_pkt_cnt), w_t'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: sample away from the rising edge, record pops, score words.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      dpop = q_dfifo_rd;
      vpop = q_vfifo_rd;
      for (int i = 0; i < NP; i++) begin
        if (q_vfifo_rd[i]) begin
          vf_cnt[i]++;
          if (first_vf_cyc < 0) first_vf_cyc = cyc;
        end
        if (q_dfifo_rd[i]) df_cnt[i]++;
      end
      if (pktin_data_valid_wr) vwr_cnt++;
      if (pktin_data_wr) begin
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        chk("valid_mirror", w_t'(pktin_data_valid), w_t'(pktin_data_valid_wr));
        if (exp_q.size() == 0) begin
          chk("unexpected_word", pktin_data, w_t'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("pkt_word", pktin_data, mon_e);
          chk("eop_strobe", w_t'(pktin_data_valid_wr), w_t'(mon_e[DATA_W-1 -: 2] == HDR_END));
        end
        if (gap_chk && pktin_data[DATA_W-1 -: 2] == HDR_START && last_end >= 0)
          chk("pkt_gap", w_t'(cyc - last_end - 1), w_t'(1));
        if (pktin_data[DATA_W-1 -: 2] == HDR_END) last_end = cyc;
      end else if (pktin_data_valid_wr) begin
        chk("stray_eop", w_t'(pktin_data_valid_wr), w_t'(0));
      end
    end else begin
      dpop = '0;
      vpop = '0;
    end
  end

  // Apply the pops the DUT requested in the cycle that just ended.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        if (dpop[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        if (vpop[i] && pcnt[i] > 0) pcnt[i]--;
      end
      refresh();
    end
    dpop = '0;
    vpop = '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int exp_cnt [NP];
    pktin_ready = 1'b0;
    q_pkt_valid = '0;
    q_dfifo_rdata = '0;
    set_w(1, 1, 1, 1);

    // Single 3-word packet on port 0.
    pktin_ready = 1'b1;
    do_reset();
    push_pkt(0, 3);
    expect_port(0);
    wait_done(50);
    chk("t1_vfifo_pulses", w_t'(vf_cnt[0]), w_t'(1));
    chk("t1_dfifo_pops",   w_t'(df_cnt[0]), w_t'(3));
    chk("t1_wr_cycles",    w_t'(wr_cnt),    w_t'(3));
    chk("t1_eop_count",    w_t'(vwr_cnt),   w_t'(1));
    chk("t1_pop_to_wr",    w_t'(first_wr_cyc - first_vf_cyc), w_t'(1));

    // Equal weights, all ports loaded: strict rotation with one idle gap.
    set_w(1, 1, 1, 1);
    do_reset();
    gap_chk = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 2 + p);
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) expect_port(p);
    wait_done(400);
    gap_chk = 1'b0;

    // Weights {3,1,0,2}: 0,0,0,1,3,3 per round, port 2 never served.
    set_w(3, 1, 0, 2);
    do_reset();
    gap_chk = 1'b1;
    for (int k = 0; k < 6; k++) push_pkt(0, 3);
    for (int k = 0; k < 2; k++) push_pkt(1, 2);
    for (int k = 0; k < 2; k++) push_pkt(2, 2);
    for (int k = 0; k < 4; k++) push_pkt(3, 4);
    for (int r = 0; r < 2; r++) begin
      expect_port(0); expect_port(0); expect_port(0);
      expect_port(1); expect_port(3); expect_port(3);
    end
    wait_done(600);
    repeat (20) @(negedge clk);
    gap_chk = 1'b0;
    chk("t3_port2_vfifo", w_t'(vf_cnt[2]), w_t'(0));
    chk("t3_port2_dfifo", w_t'(df_cnt[2]), w_t'(0));

    // Credit forfeit on port 0, then a fresh load for new port 0 packets.
    set_w(3, 1, 1, 1);
    do_reset();
    push_pkt(0, 2);
    push_pkt(1, 3);
    expect_port(0); expect_port(1);
    wait_done(100);
    for (int k = 0; k < 3; k++) push_pkt(0, 2);
    push_pkt(1, 2);
    expect_port(0); expect_port(0); expect_port(0); expect_port(1);
    wait_done(200);

    // pktin_ready gating, no preemption, reset mid-packet.
    set_w(1, 1, 1, 1);
    pktin_ready = 1'b0;
    do_reset();
    push_pkt(2, 6);
    repeat (10) @(negedge clk);
    chk("t5_no_rd_when_not_ready", w_t'(vf_cnt[2] + df_cnt[2]), w_t'(0));
    chk("t5_no_wr_when_not_ready", w_t'(wr_cnt), w_t'(0));
    expect_port(2);
    #2 pktin_ready = 1'b1;
    i = 0;
    while (vf_cnt[2] == 0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("t5_grant_seen", w_t'(vf_cnt[2] != 0), w_t'(1));
    #2 pktin_ready = 1'b0;
    wait_done(100);
    chk("t5_full_packet_pops", w_t'(df_cnt[2]), w_t'(6));
    chk("t5_eop_count",        w_t'(vwr_cnt),   w_t'(1));
    pktin_ready = 1'b1;
    push_pkt(1, 8);
    expect_port(1);
    i = 0;
    while (wr_cnt < 3 && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk("t5_midpkt_reached", w_t'(wr_cnt >= 3), w_t'(1));
    do_reset();
    repeat (6) @(negedge clk);
    chk("t5_post_reset_wr", w_t'(wr_cnt), w_t'(0));

    // Statistics: 5 packets from port 1, 2 from port 3.
    set_w(1, 1, 1, 1);
    pktin_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) push_pkt(1, 2);
    for (int k = 0; k < 2; k++) push_pkt(3, 3);
    expect_port(1); expect_port(3); expect_port(1); expect_port(3);
    expect_port(1); expect_port(1); expect_port(1);
    wait_done(300);
`ifdef PKT_WRR_STATS_EN
    exp_cnt = '{0, 5, 0, 2};
`else
    exp_cnt = '{0, 0, 0, 0};
`endif
    for (int p = 0; p < NP; p++)
      chk($sformatf("t6_stat_port%0d", p), w_t'(stat_pkt_cnt[p*32 +: 32]), w_t'(exp_cnt[p]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
